// File: rtl/calculadora_arbitro.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | calculadora_arbitro: round-robin arbiter sharing one registered calculator |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module calculadora_arbitro #(
   parameter int LARGURA = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [LARGURA-1:0] entrada_A0,
   input  logic [LARGURA-1:0] entrada_B0,
   input  logic [LARGURA-1:0] entrada_A1,
   input  logic [LARGURA-1:0] entrada_B1,
   input  logic [2:0]         codigo0,
   input  logic [2:0]         codigo1,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [LARGURA-1:0] saida,
   output logic               res_id,
   output logic               res_erro,
   output logic [7:0]         contagem
);

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      CALCULA = 2'd1,
      ENTREGA = 2'd2
   } estado_t;

   estado_t              estado_q;
   logic                 ultimo_q;
   logic [LARGURA-1:0]   a_q;
   logic [LARGURA-1:0]   b_q;
   logic [2:0]           cod_q;
   logic                 id_q;
   logic [LARGURA-1:0]   saida_q;
   logic                 res_id_q;
   logic                 res_erro_q;
   logic [7:0]           contagem_q;

   logic                 concede_d;
   logic [LARGURA-1:0]   resultado_d;
   logic                 erro_d;

   // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
   always_comb begin
      concede_d = req_valid[1] & (~req_valid[0] | ~ultimo_q);
      req_ready = 2'b00;
      if (estado_q == OCIOSO && req_valid != 2'b00) begin
         req_ready = concede_d ? 2'b10 : 2'b01;
      end
   end

   always_comb begin
      resultado_d = '0;
      erro_d      = 1'b0;
      case (cod_q)
         3'b000:  resultado_d = '0;
         3'b001:  resultado_d = a_q;
         3'b010:  resultado_d = b_q;
         3'b011:  resultado_d = a_q + b_q;
         3'b100:  resultado_d = a_q - b_q;
         default: erro_d      = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q   <= OCIOSO;
         ultimo_q   <= 1'b1;
         a_q        <= '0;
         b_q        <= '0;
         cod_q      <= 3'b000;
         id_q       <= 1'b0;
         saida_q    <= '0;
         res_id_q   <= 1'b0;
         res_erro_q <= 1'b0;
         contagem_q <= 8'd0;
      end else begin
         case (estado_q)
            OCIOSO: begin
               if (req_valid != 2'b00) begin
                  ultimo_q <= concede_d;
                  id_q     <= concede_d;
                  a_q      <= concede_d ? entrada_A1 : entrada_A0;
                  b_q      <= concede_d ? entrada_B1 : entrada_B0;
                  cod_q    <= concede_d ? codigo1    : codigo0;
                  estado_q <= CALCULA;
               end
            end
            CALCULA: begin
               saida_q    <= resultado_d;
               res_id_q   <= id_q;
               res_erro_q <= erro_d;
               estado_q   <= ENTREGA;
            end
            ENTREGA: begin
               if (res_ready) begin
                  contagem_q <= contagem_q + 8'd1;
                  estado_q   <= OCIOSO;
               end
            end
            default: estado_q <= OCIOSO;
         endcase
      end
   end

   assign res_valid = (estado_q == ENTREGA);
   assign saida     = saida_q;
   assign res_id    = res_id_q;
   assign res_erro  = res_erro_q;
   assign contagem  = contagem_q;

endmodule
`default_nettype wire

// File: tb/tb_calculadora_arbitro.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_calculadora_arbitro: directed self-checking bench for the arbiter       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_calculadora_arbitro;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req_valid = 2'b00;
   logic [1:0] req_ready;
   logic [7:0] entrada_A0 = 8'h00, entrada_B0 = 8'h00;
   logic [7:0] entrada_A1 = 8'h00, entrada_B1 = 8'h00;
   logic [2:0] codigo0 = 3'b000, codigo1 = 3'b000;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [7:0] saida;
   logic       res_id;
   logic       res_erro;
   logic [7:0] contagem;

   int n_cmp = 0;
   int n_err = 0;

   calculadora_arbitro #(.LARGURA(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .entrada_A0 (entrada_A0),
      .entrada_B0 (entrada_B0),
      .entrada_A1 (entrada_A1),
      .entrada_B1 (entrada_B1),
      .codigo0    (codigo0),
      .codigo1    (codigo1),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .saida      (saida),
      .res_id     (res_id),
      .res_erro   (res_erro),
      .contagem   (contagem)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
      n_cmp++; if (saida !== 8'h00) begin n_err++; $display("FAIL reset_saida: got %h want 00", saida); end
      n_cmp++; if (res_id !== 1'b0 || res_erro !== 1'b0) begin n_err++; $display("FAIL reset_id_erro: got %b%b want 00", res_id, res_erro); end
      n_cmp++; if (contagem !== 8'd0) begin n_err++; $display("FAIL reset_contagem: got %0d want 0", contagem); end
   endtask

   task automatic test_single();
      entrada_A0 = 8'h05; entrada_B0 = 8'h03; codigo0 = 3'b011;
      req_valid = 2'b01;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready: got %b want 01", req_ready); end
      tick();
      req_valid = 2'b00;
      entrada_A0 = 8'hFF; entrada_B0 = 8'hFF; codigo0 = 3'b000;
      #1;
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL single_ready_calc: got %b want 00", req_ready); end
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_early: got %b want 0", res_valid); end
      tick();
      n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", res_valid); end
      n_cmp++; if (saida !== 8'h08) begin n_err++; $display("FAIL single_saida: got %h want 08", saida); end
      n_cmp++; if (res_id !== 1'b0 || res_erro !== 1'b0) begin n_err++; $display("FAIL single_id_erro: got %b%b want 00", res_id, res_erro); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      #1;
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_after: got %b want 0", res_valid); end
      n_cmp++; if (contagem !== 8'd1) begin n_err++; $display("FAIL single_contagem: got %0d want 1", contagem); end
   endtask

   task automatic test_wrap();
      entrada_A1 = 8'hF0; entrada_B1 = 8'h20; codigo1 = 3'b011;
      req_valid = 2'b10;
      #1;
      n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL wrap_add_ready: got %b want 10", req_ready); end
      tick();
      req_valid = 2'b00;
      tick();
      n_cmp++; if (saida !== 8'h10 || res_id !== 1'b1) begin n_err++; $display("FAIL wrap_add: got %h id %b want 10 id 1", saida, res_id); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      entrada_A1 = 8'h02; entrada_B1 = 8'h05; codigo1 = 3'b100;
      req_valid = 2'b10;
      #1;
      n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL wrap_sub_ready: got %b want 10", req_ready); end
      tick();
      req_valid = 2'b00;
      tick();
      n_cmp++; if (saida !== 8'hFD || res_id !== 1'b1 || res_erro !== 1'b0) begin n_err++; $display("FAIL wrap_sub: got %h id %b erro %b want FD id 1 erro 0", saida, res_id, res_erro); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      #1;
      n_cmp++; if (contagem !== 8'd3) begin n_err++; $display("FAIL wrap_contagem: got %0d want 3", contagem); end
   endtask

   task automatic test_tie();
      int gcyc[8];
      int gid[8];
      int ng = 0;
      entrada_A0 = 8'h01; entrada_B0 = 8'h02; codigo0 = 3'b011;
      entrada_A1 = 8'h09; entrada_B1 = 8'h04; codigo1 = 3'b100;
      req_valid = 2'b11;
      res_ready = 1'b1;
      #1;
      for (int i = 0; i < 12; i++) begin
         n_cmp++; if (req_ready === 2'b11) begin n_err++; $display("FAIL tie_both_ready: cycle %0d got 11 want one-hot or 00", i); end
         if (req_ready != 2'b00 && ng < 8) begin
            gcyc[ng] = i;
            gid[ng]  = (req_ready == 2'b10) ? 1 : 0;
            ng++;
         end
         if (i % 3 == 2) begin
            n_cmp++;
            if (res_valid !== 1'b1 || res_id !== 1'((i / 3) % 2) || saida !== (((i / 3) % 2) == 1 ? 8'h05 : 8'h03)) begin
               n_err++; $display("FAIL tie_result: cycle %0d got v%b id %b %h", i, res_valid, res_id, saida);
            end
         end
         tick();
      end
      req_valid = 2'b00;
      res_ready = 1'b0;
      #1;
      n_cmp++; if (ng !== 4) begin n_err++; $display("FAIL tie_grant_count: got %0d want 4", ng); end
      for (int k = 0; k < 4; k++) begin
         if (k < ng) begin
            n_cmp++; if (gcyc[k] !== 3 * k || gid[k] !== k % 2) begin n_err++; $display("FAIL tie_grant_%0d: got cycle %0d id %0d want cycle %0d id %0d", k, gcyc[k], gid[k], 3 * k, k % 2); end
         end
      end
      n_cmp++; if (contagem !== 8'd7) begin n_err++; $display("FAIL tie_contagem: got %0d want 7", contagem); end
   endtask

   task automatic test_backpressure();
      entrada_A0 = 8'hAA; entrada_B0 = 8'h00; codigo0 = 3'b001;
      entrada_A1 = 8'h11; entrada_B1 = 8'h22; codigo1 = 3'b001;
      req_valid = 2'b01;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_ready: got %b want 01", req_ready); end
      tick();
      req_valid = 2'b10;
      tick();
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if (res_valid !== 1'b1 || saida !== 8'hAA || req_ready !== 2'b00) begin
            n_err++; $display("FAIL bp_hold: cycle %0d got v%b %h rdy %b want v1 AA rdy 00", i, res_valid, saida, req_ready);
         end
         tick();
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      #1;
      n_cmp++; if (contagem !== 8'd8 || res_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got cnt %0d v%b want 8 v0", contagem, res_valid); end
      n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_pending: got %b want 10", req_ready); end
      tick();
      req_valid = 2'b00;
      tick();
      n_cmp++; if (saida !== 8'h11 || res_id !== 1'b1) begin n_err++; $display("FAIL bp_pending_result: got %h id %b want 11 id 1", saida, res_id); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      #1;
      n_cmp++; if (contagem !== 8'd9) begin n_err++; $display("FAIL bp_contagem: got %0d want 9", contagem); end
   endtask

   task automatic test_invalid();
      entrada_A0 = 8'h12; entrada_B0 = 8'h34; codigo0 = 3'b110;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick();
      n_cmp++; if (saida !== 8'h00 || res_erro !== 1'b1) begin n_err++; $display("FAIL inv_result: got %h erro %b want 00 erro 1", saida, res_erro); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      codigo0 = 3'b010;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick();
      n_cmp++; if (saida !== 8'h34 || res_erro !== 1'b0) begin n_err++; $display("FAIL inv_next: got %h erro %b want 34 erro 0", saida, res_erro); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      #1;
      n_cmp++; if (contagem !== 8'd11) begin n_err++; $display("FAIL inv_contagem: got %0d want 11", contagem); end
   endtask

   task automatic test_reset_mid();
      entrada_A0 = 8'h01; entrada_B0 = 8'h01; codigo0 = 3'b011;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick();
      n_cmp++; if (res_valid !== 1'b1 || saida !== 8'h02) begin n_err++; $display("FAIL mid_entrega: got v%b %h want v1 02", res_valid, saida); end
      rst = 1'b1;
      res_ready = 1'b1;
      tick();
      rst = 1'b0;
      res_ready = 1'b0;
      #1;
      n_cmp++; if (res_valid !== 1'b0 || contagem !== 8'd0 || saida !== 8'h00) begin n_err++; $display("FAIL mid_reset: got v%b cnt %0d %h want v0 0 00", res_valid, contagem, saida); end
      entrada_A1 = 8'h00; entrada_B1 = 8'h00; codigo1 = 3'b000;
      req_valid = 2'b11;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_tie_first: got %b want 01", req_ready); end
      res_ready = 1'b1;
      for (int i = 0; i < 765; i++) tick();
      n_cmp++; if (contagem !== 8'd255) begin n_err++; $display("FAIL mid_cnt255: got %0d want 255", contagem); end
      for (int i = 0; i < 3; i++) tick();
      n_cmp++; if (contagem !== 8'd0) begin n_err++; $display("FAIL mid_cnt_wrap: got %0d want 0", contagem); end
      req_valid = 2'b00;
      res_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_tie();
      test_backpressure();
      test_invalid();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
